ultrasonic_ctrl: RTL

Measurement sequencer for the HC-SR04-style ultrasonic ranger on the 25 MHz system clock. Fires a 10 us trigger pulse and synchronises the returned echo. Times the echo width directly in centimetres and enforces the sensor's minimum cycle period. Sits between the sensor pins and the distance display/consumer logic, and replaces free-running trigger generation.

---
 rtl/ultrasonic_ctrl_if.sv | 21 ++
 rtl/ultrasonic_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ctrl_if.sv
// Pin-level bundle between the ultrasonic ranger sequencer and its user.
// master drives start/echo, slave is the sequencer.
interface ultrasonic_ctrl_if;
   logic       start;
   logic       echo;
   logic       trig;
   logic       busy;
   logic [8:0] distance;
   logic       valid;
   logic       timeout;

   modport master (
      output start, echo,
      input  trig, busy, distance, valid, timeout
   );

   modport slave (
      input  start, echo,
      output trig, busy, distance, valid, timeout
   );
endinterface

// File: rtl/ultrasonic_ctrl.sv
// HC-SR04 measurement sequencer: trigger pulse, echo timing in cm, period guard.
// Define ULTRASONIC_AUTO_EN for free-running measurements without start.
module ultrasonic_ctrl #(
   parameter int TRIG_CYCLES   = 250,
   parameter int CM_CYCLES     = 1450,
   parameter int MAX_CM        = 400,
   parameter int WAIT_LIMIT    = 500000,
   parameter int PERIOD_CYCLES = 1500000
) (
   input  logic              clk_in,
   input  logic              rst_n,
   ultrasonic_ctrl_if.slave  bus
);

   localparam int C1  = (TRIG_CYCLES > WAIT_LIMIT) ? TRIG_CYCLES : WAIT_LIMIT;
   localparam int CMX = (C1 > CM_CYCLES) ? C1 : CM_CYCLES;
   localparam int CW  = $clog2(CMX + 1);
   localparam int PW  = $clog2(PERIOD_CYCLES + 1);

   localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);
   localparam logic [CW-1:0] CM_LAST   = CW'(CM_CYCLES - 1);
   localparam logic [PW-1:0] PER_MAX   = PW'(PERIOD_CYCLES);
   localparam logic [8:0]    MAX_D     = 9'(MAX_CM);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_ECHO,
      MEASURE,
      HOLDOFF
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [8:0]      cm_q, cm_d;
   logic [PW-1:0]   per_q, per_d;
   logic            echo_m_q, echo_s_q, echo_d_q;
   logic [8:0]      dist_q, dist_d;
   logic            tout_q, tout_d;
   logic            valid_q, valid_d;
   logic            rise, fall;

   assign rise = echo_s_q & ~echo_d_q;
   assign fall = ~echo_s_q & echo_d_q;

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cm_q     <= '0;
         per_q    <= '0;
         echo_m_q <= 1'b0;
         echo_s_q <= 1'b0;
         echo_d_q <= 1'b0;
         dist_q   <= '0;
         tout_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cm_q     <= cm_d;
         per_q    <= per_d;
         echo_m_q <= bus.echo;
         echo_s_q <= echo_m_q;
         echo_d_q <= echo_s_q;
         dist_q   <= dist_d;
         tout_q   <= tout_d;
         valid_q  <= valid_d;
      end
   end

`ifdef ULTRASONIC_AUTO_EN
   logic unused_start;
   assign unused_start = bus.start;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cm_d    = cm_q;
      per_d   = (per_q == PER_MAX) ? per_q : per_q + 1'b1;
      dist_d  = dist_q;
      tout_d  = tout_q;
      valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
`ifdef ULTRASONIC_AUTO_EN
            state_d = TRIG;
            cnt_d   = '0;
            per_d   = '0;
`else
            if (bus.start) begin
               state_d = TRIG;
               cnt_d   = '0;
               per_d   = '0;
            end
`endif
         end
         TRIG: begin
            if (cnt_q == TRIG_LAST) begin
               state_d = WAIT_ECHO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_ECHO: begin
            // the rise cycle itself is the first counted high cycle
            if (rise) begin
               state_d = MEASURE;
               cnt_d   = CW'(1);
               cm_d    = '0;
            end else if (cnt_q == WAIT_LAST) begin
               state_d = HOLDOFF;
               dist_d  = '0;
               tout_d  = 1'b1;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         MEASURE: begin
            if (cm_q == MAX_D) begin
               state_d = HOLDOFF;
               dist_d  = MAX_D;
               tout_d  = 1'b1;
               valid_d = 1'b1;
            end else if (fall) begin
               state_d = HOLDOFF;
               dist_d  = cm_q;
               tout_d  = 1'b0;
               valid_d = 1'b1;
            end else if (cnt_q == CM_LAST) begin
               cnt_d = '0;
               cm_d  = cm_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLDOFF: begin
`ifdef ULTRASONIC_AUTO_EN
            // leave one cycle early so trig rises exactly every period
            if (per_q >= PER_MAX - 1'b1) begin
               state_d = TRIG;
               cnt_d   = '0;
               per_d   = '0;
            end
`else
            if (per_q == PER_MAX) begin
               state_d = IDLE;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.trig     = (state_q == TRIG);
   assign bus.busy     = (state_q != IDLE);
   assign bus.distance = dist_q;
   assign bus.valid    = valid_q;
   assign bus.timeout  = tout_q;

endmodule
